piso_register: RTL
==================

// Module: piso_register
// PURPOSE
//   Parallel-in/serial-out shift register: the read-out end for parallel words
//   held by the 4-bit storage registers. It captures one WIDTH-bit word through a
//   valid/ready handshake, then shifts it out one bit per clock with a valid
//   strobe and an end-of-word pulse. It sits between register banks and
//   single-wire consumers such as serial links and bit-serial arithmetic.
// PARAMETERS
//   WIDTH      4   bits per word (>= 2)
//   MSB_FIRST  1   1: shift out D[WIDTH-1] first; 0: shift out D[0] first
// PORTS
//   clk         in   1      clock, rising edge
//   clr_n       in   1      asynchronous active-low reset
//   load_valid  in   1      D holds a word to be serialized
//   load_ready  out  1      block accepts a word this cycle (combinational from state)
//   D           in   WIDTH  parallel word, sampled on the accept edge
//   abort       in   1      synchronous abort of the current word
//   sout        out  1      serial data bit (registered)
//   sout_valid  out  1      sout carries a bit of a word (registered)
//   busy        out  1      a word is being shifted (registered)
//   done        out  1      high for exactly the cycle of a word's last bit
// BEHAVIOUR
//   State:    IDLE, SHIFT; shift register shreg[WIDTH-1:0]; down-counter cnt.
//   Reset:    clr_n=0 forces IDLE at once, independent of clk.
//             Output values in reset: sout=0, sout_valid=0, busy=0, done=0,
//             load_ready=1. shreg and cnt clear to 0.
//   Accept:   the word is accepted at a rising edge where load_valid && load_ready.
//             load_ready = (IDLE) || (SHIFT && cnt==0).
//   Latency:  D is accepted at edge k. Its first bit appears on sout after edge k,
//             and the word occupies exactly WIDTH consecutive cycles with
//             sout_valid=1 and busy=1.
//   Order:    MSB_FIRST=1 sends D[WIDTH-1] down to D[0]. MSB_FIRST=0 sends D[0]
//             up to D[WIDTH-1].
//   Counter:  cnt loads WIDTH-1 on accept and decrements once per SHIFT cycle.
//             done = SHIFT && cnt==0.
//   IDLE:     sout=0, sout_valid=0, busy=0, done=0. load_valid is ignored while
//             load_ready=0.
//   Last bit: in the cycle with cnt==0:
//             - if a word is accepted, the next edge goes straight into that
//               word's first bit (zero-bubble back-to-back);
//             - otherwise the next edge returns to IDLE.
//   Abort:    abort=1 at an edge sends the block to IDLE and clears sout,
//             sout_valid, busy and done at that edge. Abort has priority over a
//             simultaneous accept: that word is dropped and not accepted.
//   Mid-word: load_valid in SHIFT with cnt!=0 has no effect. D is not resampled.
// TESTING
//   1 Reset: clr_n=0 for 2 cycles, released between edges -> outputs 0,
//     load_ready=1, no sout_valid for 5 idle cycles.
//   2 Single word, MSB_FIRST=1: D=4'b1011 accepted at edge k -> sout=1,0,1,1
//     on cycles k+1..k+4 with sout_valid=1. done only on cycle k+4. Back to
//     IDLE at k+5.
//   3 Back-to-back: 4'b1011 then 4'b0110, load_valid held -> 8 continuous bits
//     1,0,1,1,0,1,1,0. sout_valid never drops. done on bits 4 and 8.
//   4 Blocked load: D=4'b1111 offered on cycle k+2 of word 4'b0000 ->
//     load_ready=0, sout stays 0,0,0,0, and the word is not accepted until the
//     last-bit cycle.
//   5 Abort and async reset: abort on the 2nd bit of 4'b1100 -> IDLE at the next
//     edge, sout_valid=0. Repeat with clr_n pulsed low between edges mid-word
//     -> outputs clear immediately.
//   6 MSB_FIRST=0, WIDTH=8: D=8'hA5 -> sout=1,0,1,0,0,1,0,1, done on the 8th bit.

Source files
------------

// File: rtl/piso_register.sv
// Parallel-in/serial-out shift register: accepts one WIDTH-bit word via valid/ready
// and shifts it out one bit per clock with a valid strobe and a last-bit pulse.
module piso_register #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] D,
    input  logic             abort,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] d_ord;
    logic             last;
    logic             accept;

    // Reorder the word so the bit sent first always sits at the top of shreg.
    always_comb begin
        d_ord = D;
        for (int i = 0; i < int'(WIDTH); i++) begin
            d_ord[i] = MSB_FIRST ? D[i] : D[int'(WIDTH) - 1 - i];
        end
    end

    assign last       = (state == SHIFT) && (cnt == '0);
    assign load_ready = (state == IDLE) || last;
    assign accept     = load_valid && load_ready;

    // Abort beats accept; on the last bit an accept chains straight into the next word.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if ((state == SHIFT) && !last) begin
            cnt        <= cnt - CW'(1);
            sout       <= shreg[WIDTH-1];
            shreg      <= {shreg[WIDTH-2:0], 1'b0};
            done       <= (cnt == CW'(1));
        end else if (accept) begin
            state      <= SHIFT;
            cnt        <= CW'(WIDTH - 1);
            sout       <= d_ord[WIDTH-1];
            shreg      <= {d_ord[WIDTH-2:0], 1'b0};
            sout_valid <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end
    end

endmodule
